liteic_axil_regfile: RTL and testbench

LITEIC_AXIL_REGFILE -- requirements
Module: liteic_axil_regfile

---
 rtl/liteic_axil_regfile_pkg.sv | 28 ++
 rtl/axi_lite_if.sv | 42 ++++
 rtl/liteic_axil_regfile_decode.sv | 19 +
 rtl/liteic_axil_regfile.sv | 245 ++++++++++++++++++++++++
 tb/tb_liteic_axil_regfile.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/liteic_axil_regfile_pkg.sv
// Shared types and constants for the AXI-Lite register file.
package liteic_regfile_pkg;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  // Merge new write data into an old word, byte lanes selected by strobe.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle with all five channels; sp is the subordinate view.
interface axi_lite_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESP_WIDTH = 1
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [3:0]              aw_qos;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [RESP_WIDTH-1:0]   b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [3:0]              ar_qos;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [RESP_WIDTH-1:0]   r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport sp (
    input  aw_addr, aw_qos, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid,   output w_ready,
    output b_resp, b_valid,           input  b_ready,
    input  ar_addr, ar_qos, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid,   input  r_ready
  );

  modport mp (
    output aw_addr, aw_qos, aw_valid, input  aw_ready,
    output w_data, w_strb, w_valid,   input  w_ready,
    input  b_resp, b_valid,           output b_ready,
    output ar_addr, ar_qos, ar_valid, input  ar_ready,
    input  r_data, r_resp, r_valid,   output r_ready
  );
endinterface

// File: rtl/liteic_axil_regfile_decode.sv
// Register address decode: hit when inside the aligned window and word aligned.
module liteic_regfile_decode #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           REG_NUM    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic [ADDR_WIDTH-1:0]      addr,
  output logic                       hit,
  output logic [$clog2(REG_NUM)-1:0] idx
);
  localparam int unsigned IDX_W = $clog2(REG_NUM);

  // Base is aligned to the window size, so upper bits identify the window.
  always_comb begin
    hit = (addr[ADDR_WIDTH-1:IDX_W+2] == BASE_ADDR[ADDR_WIDTH-1:IDX_W+2]) &&
          (addr[1:0] == 2'b00);
    idx = addr[IDX_W+1:2];
  end
endmodule

// File: rtl/liteic_axil_regfile.sv
// AXI-Lite register file: independent read and write FSMs, flop-backed registers.
module liteic_axil_regfile
  import liteic_regfile_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           RESP_WIDTH = 1,
  parameter int unsigned           REG_NUM    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  axi_lite_if.sp                        s_axil,
  output logic [REG_NUM*DATA_WIDTH-1:0] regs_o,
  output logic [REG_NUM-1:0]            wr_pulse_o
);
  localparam int unsigned IDX_W = $clog2(REG_NUM);

  logic [DATA_WIDTH-1:0]   regs_r [REG_NUM];

  wr_state_t               wr_state_r, wr_state_s;
  logic                    aw_ready_r, aw_ready_s, w_ready_r, w_ready_s;
  logic                    aw_held_r, aw_held_s, w_held_r, w_held_s;
  logic [ADDR_WIDTH-1:0]   aw_addr_r, aw_addr_s, wr_addr_s;
  logic [DATA_WIDTH-1:0]   w_data_r, w_data_s, wr_data_s;
  logic [DATA_WIDTH/8-1:0] w_strb_r, w_strb_s, wr_strb_s;
  logic                    b_valid_r, b_valid_s;
  logic [RESP_WIDTH-1:0]   b_resp_r, b_resp_s;
  logic [REG_NUM-1:0]      wr_pulse_r, wr_pulse_s;
  logic                    aw_hs_s, w_hs_s, commit_s, wr_hit_s;
  logic [IDX_W-1:0]        wr_idx_s;

  rd_state_t               rd_state_r, rd_state_s;
  logic                    ar_ready_r, ar_ready_s, r_valid_r, r_valid_s;
  logic [DATA_WIDTH-1:0]   r_data_r, r_data_s;
  logic [RESP_WIDTH-1:0]   r_resp_r, r_resp_s;
  logic                    ar_hs_s, rd_hit_s;
  logic [IDX_W-1:0]        rd_idx_s;

  liteic_regfile_decode #(.ADDR_WIDTH(ADDR_WIDTH), .REG_NUM(REG_NUM), .BASE_ADDR(BASE_ADDR))
    u_wr_decode (.addr(wr_addr_s), .hit(wr_hit_s), .idx(wr_idx_s));

  liteic_regfile_decode #(.ADDR_WIDTH(ADDR_WIDTH), .REG_NUM(REG_NUM), .BASE_ADDR(BASE_ADDR))
    u_rd_decode (.addr(s_axil.ar_addr), .hit(rd_hit_s), .idx(rd_idx_s));

  // Pick captured AW/W or the live channel, and detect the commit edge.
  always_comb begin
    aw_hs_s = s_axil.aw_valid & aw_ready_r;
    w_hs_s  = s_axil.w_valid & w_ready_r;
    if (aw_held_r) begin
      wr_addr_s = aw_addr_r;
    end else begin
      wr_addr_s = s_axil.aw_addr;
    end
    if (w_held_r) begin
      wr_data_s = w_data_r;
      wr_strb_s = w_strb_r;
    end else begin
      wr_data_s = s_axil.w_data;
      wr_strb_s = s_axil.w_strb;
    end
    commit_s = (wr_state_r == W_IDLE) & (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
  end

  // Write FSM next-state and next-output logic.
  always_comb begin
    wr_state_s = wr_state_r;
    aw_ready_s = aw_ready_r;
    w_ready_s  = w_ready_r;
    aw_held_s  = aw_held_r;
    w_held_s   = w_held_r;
    aw_addr_s  = aw_addr_r;
    w_data_s   = w_data_r;
    w_strb_s   = w_strb_r;
    b_valid_s  = b_valid_r;
    b_resp_s   = b_resp_r;
    wr_pulse_s = {REG_NUM{1'b0}};
    case (wr_state_r)
      W_IDLE: begin
        if (commit_s) begin
          wr_state_s = W_RESP;
          aw_ready_s = 1'b0;
          w_ready_s  = 1'b0;
          aw_held_s  = 1'b0;
          w_held_s   = 1'b0;
          b_valid_s  = 1'b1;
          if (wr_hit_s) begin
            b_resp_s             = RESP_WIDTH'(RESP_OKAY);
            wr_pulse_s[wr_idx_s] = 1'b1;
          end else begin
            b_resp_s = RESP_WIDTH'(RESP_SLVERR);
          end
        end else begin
          if (aw_hs_s) begin
            aw_held_s  = 1'b1;
            aw_addr_s  = s_axil.aw_addr;
            aw_ready_s = 1'b0;
          end else begin
            aw_ready_s = ~aw_held_r;
          end
          if (w_hs_s) begin
            w_held_s  = 1'b1;
            w_data_s  = s_axil.w_data;
            w_strb_s  = s_axil.w_strb;
            w_ready_s = 1'b0;
          end else begin
            w_ready_s = ~w_held_r;
          end
        end
      end
      W_RESP: begin
        if (s_axil.b_ready) begin
          wr_state_s = W_IDLE;
          b_valid_s  = 1'b0;
          b_resp_s   = RESP_WIDTH'(RESP_OKAY);
          aw_ready_s = 1'b1;
          w_ready_s  = 1'b1;
        end else begin
          b_valid_s = 1'b1;
        end
      end
      default: begin
        wr_state_s = W_IDLE;
        aw_ready_s = 1'b0;
        w_ready_s  = 1'b0;
        aw_held_s  = 1'b0;
        w_held_s   = 1'b0;
        b_valid_s  = 1'b0;
      end
    endcase
  end

  // Write FSM state and registered write-channel outputs.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_state_r <= W_IDLE;
      aw_ready_r <= 1'b0;
      w_ready_r  <= 1'b0;
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      aw_addr_r  <= {ADDR_WIDTH{1'b0}};
      w_data_r   <= {DATA_WIDTH{1'b0}};
      w_strb_r   <= {(DATA_WIDTH/8){1'b0}};
      b_valid_r  <= 1'b0;
      b_resp_r   <= {RESP_WIDTH{1'b0}};
      wr_pulse_r <= {REG_NUM{1'b0}};
    end else begin
      wr_state_r <= wr_state_s;
      aw_ready_r <= aw_ready_s;
      w_ready_r  <= w_ready_s;
      aw_held_r  <= aw_held_s;
      w_held_r   <= w_held_s;
      aw_addr_r  <= aw_addr_s;
      w_data_r   <= w_data_s;
      w_strb_r   <= w_strb_s;
      b_valid_r  <= b_valid_s;
      b_resp_r   <= b_resp_s;
      wr_pulse_r <= wr_pulse_s;
    end
  end

  // Register storage; only in-range commits touch it, strobed bytes only.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int k = 0; k < int'(REG_NUM); k++) begin
        regs_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else if (commit_s && wr_hit_s) begin
      regs_r[wr_idx_s] <= strb_merge(regs_r[wr_idx_s], wr_data_s, wr_strb_s);
    end
  end

  // Read FSM next-state; data is taken from the pre-commit register value.
  always_comb begin
    ar_hs_s    = s_axil.ar_valid & ar_ready_r;
    rd_state_s = rd_state_r;
    ar_ready_s = ar_ready_r;
    r_valid_s  = r_valid_r;
    r_data_s   = r_data_r;
    r_resp_s   = r_resp_r;
    case (rd_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          rd_state_s = R_RESP;
          ar_ready_s = 1'b0;
          r_valid_s  = 1'b1;
          if (rd_hit_s) begin
            r_data_s = regs_r[rd_idx_s];
            r_resp_s = RESP_WIDTH'(RESP_OKAY);
          end else begin
            r_data_s = {DATA_WIDTH{1'b0}};
            r_resp_s = RESP_WIDTH'(RESP_SLVERR);
          end
        end else begin
          ar_ready_s = 1'b1;
        end
      end
      R_RESP: begin
        if (s_axil.r_ready) begin
          rd_state_s = R_IDLE;
          r_valid_s  = 1'b0;
          ar_ready_s = 1'b1;
        end else begin
          r_valid_s = 1'b1;
        end
      end
      default: begin
        rd_state_s = R_IDLE;
        ar_ready_s = 1'b0;
        r_valid_s  = 1'b0;
      end
    endcase
  end

  // Read FSM state and registered read-channel outputs.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rd_state_r <= R_IDLE;
      ar_ready_r <= 1'b0;
      r_valid_r  <= 1'b0;
      r_data_r   <= {DATA_WIDTH{1'b0}};
      r_resp_r   <= {RESP_WIDTH{1'b0}};
    end else begin
      rd_state_r <= rd_state_s;
      ar_ready_r <= ar_ready_s;
      r_valid_r  <= r_valid_s;
      r_data_r   <= r_data_s;
      r_resp_r   <= r_resp_s;
    end
  end

  assign s_axil.aw_ready = aw_ready_r;
  assign s_axil.w_ready  = w_ready_r;
  assign s_axil.b_valid  = b_valid_r;
  assign s_axil.b_resp   = b_resp_r;
  assign s_axil.ar_ready = ar_ready_r;
  assign s_axil.r_valid  = r_valid_r;
  assign s_axil.r_data   = r_data_r;
  assign s_axil.r_resp   = r_resp_r;
  assign wr_pulse_o      = wr_pulse_r;

  for (genvar g = 0; g < int'(REG_NUM); g++) begin : g_regs_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
  end
endmodule

// File: tb/tb_liteic_axil_regfile.sv
// Scoreboard bench for liteic_axil_regfile: directed vectors, decoupled monitor.
module tb_liteic_axil_regfile;
  logic         clk;
  logic         arstn;
  logic [511:0] regs;
  logic [15:0]  pulse;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_WIDTH(1)) axil ();

  liteic_axil_regfile #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_WIDTH(1), .REG_NUM(16), .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk_i(clk), .arstn_i(arstn), .s_axil(axil), .regs_o(regs), .wr_pulse_o(pulse)
  );

  typedef struct {
    logic        resp;
    logic [31:0] data;
  } exp_t;

  exp_t        b_q[$];
  exp_t        r_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] mdl [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string name);
    logic [511:0] e;
    for (int k = 0; k < 16; k++) e[k*32 +: 32] = mdl[k];
    check(name, regs, e);
  endtask

  // Monitor: pop expectations whenever a response handshake is about to occur.
  always @(negedge clk) begin
    if (arstn) begin
      if (axil.b_valid && axil.b_ready) begin
        if (b_q.size() == 0) begin
          check("b_unexpected", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = b_q.pop_front();
          check("b_resp", axil.b_resp, e.resp);
        end
      end
      if (axil.r_valid && axil.r_ready) begin
        if (r_q.size() == 0) begin
          check("r_unexpected", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = r_q.pop_front();
          check("r_resp", axil.r_resp, e.resp);
          check("r_data", axil.r_data, e.data);
        end
      end
    end
  end

  task automatic push_b(input logic resp);
    exp_t e;
    e.resp = resp;
    e.data = 32'h0;
    b_q.push_back(e);
  endtask

  task automatic push_r(input logic resp, input logic [31:0] data);
    exp_t e;
    e.resp = resp;
    e.data = data;
    r_q.push_back(e);
  endtask

  // Present W, then AW w_lead cycles later (0 = same cycle); returns after both accepted.
  task automatic send_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int w_lead);
    bit aw_done = 1'b0, w_done = 1'b0, aw_f, w_f;
    axil.aw_addr = a;
    axil.w_data  = d;
    axil.w_strb  = s;
    axil.w_valid = 1'b1;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      if (c >= w_lead && !aw_done) axil.aw_valid = 1'b1;
      aw_f = axil.aw_valid && axil.aw_ready;
      w_f  = axil.w_valid && axil.w_ready;
      tick();
      if (aw_f) begin aw_done = 1'b1; axil.aw_valid = 1'b0; end
      if (w_f)  begin w_done  = 1'b1; axil.w_valid  = 1'b0; end
      if (w_done && !aw_done) begin
        check("w_ready_low_awaiting_aw", axil.w_ready, 1'b0);
        check("b_valid_before_aw", axil.b_valid, 1'b0);
      end
    end
    axil.aw_valid = 1'b0;
    axil.w_valid  = 1'b0;
    check("aw_w_accepted", aw_done && w_done, 1'b1);
  endtask

  task automatic send_read(input logic [31:0] a);
    bit done = 1'b0;
    axil.ar_addr  = a;
    axil.ar_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      done = axil.ar_ready;
      tick();
    end
    axil.ar_valid = 1'b0;
    check("ar_accepted", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arstn = 1'b0;
    axil.aw_addr = 32'h0; axil.aw_qos = 4'h0; axil.aw_valid = 1'b0;
    axil.w_data = 32'h0; axil.w_strb = 4'h0; axil.w_valid = 1'b0;
    axil.b_ready = 1'b1;
    axil.ar_addr = 32'h0; axil.ar_qos = 4'h0; axil.ar_valid = 1'b0;
    axil.r_ready = 1'b1;
    for (int k = 0; k < 16; k++) mdl[k] = 32'h0;

    // Reset state
    tick(); tick();
    check("rst_aw_ready", axil.aw_ready, 1'b0);
    check("rst_w_ready", axil.w_ready, 1'b0);
    check("rst_ar_ready", axil.ar_ready, 1'b0);
    check("rst_b_valid", axil.b_valid, 1'b0);
    check("rst_r_valid", axil.r_valid, 1'b0);
    check("rst_pulse", pulse, 16'h0);
    check_regs("rst_regs");
    arstn = 1'b1;
    tick();
    check("post_rst_readys", {axil.aw_ready, axil.w_ready, axil.ar_ready}, 3'b111);

    // AW and W in the same cycle
    push_b(1'b0);
    send_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0);
    mdl[2] = 32'hDEAD_BEEF;
    check("same_cycle_b_valid", axil.b_valid, 1'b1);
    check("same_cycle_pulse", pulse, 16'h0004);
    check_regs("same_cycle_regs");
    tick();
    check("pulse_one_cycle", pulse, 16'h0000);

    // W three cycles ahead of AW, partial strobe
    push_b(1'b0);
    send_write(32'h04, 32'h1122_3344, 4'h5, 3);
    mdl[1] = 32'h0022_0044;
    check("w_first_pulse", pulse, 16'h0002);
    check_regs("w_first_regs");
    tick();

    // Out-of-range and unaligned reads, then good reads
    push_r(1'b1, 32'h0);              send_read(32'h40);
    push_r(1'b1, 32'h0);              send_read(32'h06);
    push_r(1'b0, 32'hDEAD_BEEF);      send_read(32'h08);
    push_r(1'b0, 32'h0022_0044);      send_read(32'h04);

    // Out-of-range write: error response, no change
    push_b(1'b1);
    send_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0);
    check("oor_pulse", pulse, 16'h0);
    check_regs("oor_regs");
    tick();
    check("oor_pulse_after", pulse, 16'h0);

    // B back-pressure
    axil.b_ready = 1'b0;
    push_b(1'b0);
    send_write(32'h10, 32'hCAFE_F00D, 4'hF, 0);
    mdl[4] = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_stall_valid_resp", {axil.b_valid, axil.b_resp}, 2'b10);
      check("b_stall_readys", {axil.aw_ready, axil.w_ready}, 2'b00);
    end
    axil.b_ready = 1'b1;
    tick();

    // R back-pressure
    axil.r_ready = 1'b0;
    push_r(1'b0, 32'hDEAD_BEEF);
    send_read(32'h08);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("r_stall_valid", axil.r_valid, 1'b1);
      check("r_stall_data", axil.r_data, 32'hDEAD_BEEF);
      check("r_stall_ar_ready", axil.ar_ready, 1'b0);
    end
    axil.r_ready = 1'b1;
    tick();

    // Read sampled on the same edge a write commits returns the old value
    push_b(1'b0);
    send_write(32'h0C, 32'h0000_0003, 4'hF, 0);
    tick();
    check("pre_collide_readys", {axil.aw_ready, axil.w_ready, axil.ar_ready}, 3'b111);
    push_b(1'b0);
    push_r(1'b0, 32'h0000_0003);
    axil.aw_addr = 32'h0C; axil.aw_valid = 1'b1;
    axil.w_data = 32'h5; axil.w_strb = 4'hF; axil.w_valid = 1'b1;
    axil.ar_addr = 32'h0C; axil.ar_valid = 1'b1;
    tick();
    axil.aw_valid = 1'b0; axil.w_valid = 1'b0; axil.ar_valid = 1'b0;
    mdl[3] = 32'h5;
    check("collide_pulse", pulse, 16'h0008);
    tick();
    push_r(1'b0, 32'h0000_0005);
    send_read(32'h0C);
    tick();
    check_regs("collide_regs");

    // Reset pulsed while a write response is pending
    axil.b_ready = 1'b0;
    push_b(1'b0);
    send_write(32'h14, 32'h1234_5678, 4'hF, 0);
    tick();
    check("pre_rst_b_valid", axil.b_valid, 1'b1);
    #2;
    arstn = 1'b0;
    b_q.delete();
    r_q.delete();
    for (int k = 0; k < 16; k++) mdl[k] = 32'h0;
    #1;
    check("mid_rst_b_valid", axil.b_valid, 1'b0);
    check_regs("mid_rst_regs");
    tick();
    check("mid_rst_readys", {axil.aw_ready, axil.w_ready, axil.ar_ready}, 3'b000);
    arstn = 1'b1;
    axil.b_ready = 1'b1;
    tick();
    check("post_mid_rst_readys", {axil.aw_ready, axil.w_ready, axil.ar_ready}, 3'b111);
    push_r(1'b0, 32'h0);
    send_read(32'h14);

    // Drain outstanding expectations
    for (int i = 0; i < 50 && (b_q.size() != 0 || r_q.size() != 0); i++) tick();
    check("drain", b_q.size() + r_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
